// File: rtl/grid_interp_pkg.sv
// Shared types and default sizing for the grid interpolator.
package grid_interp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_LOG2_DIV = 5;

endpackage

// File: rtl/grid_interp_acc.sv
// Interpolation datapath: holds first marker, signed span and the running
// k*diff accumulator, and forms first + floor(k*diff / 2^LOG2_DIV).
module grid_interp_acc
  import grid_interp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOG2_DIV = DEF_LOG2_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] first_x_i,
  input  logic [WIDTH-1:0] sec_x_i,
  output logic [WIDTH-1:0] x_o
);

  localparam int AW = WIDTH + LOG2_DIV + 1;

  logic        [WIDTH-1:0] first_q, first_d;
  logic signed [WIDTH:0]   diff_q, diff_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic        [WIDTH:0]   sum;
  logic                    unused_sum_msb;

  always_comb begin
    first_d = first_q;
    diff_d  = diff_q;
    acc_d   = acc_q;
    if (load_i) begin
      first_d = first_x_i;
      diff_d  = $signed({1'b0, sec_x_i}) - $signed({1'b0, first_x_i});
      acc_d   = '0;
    end else if (step_i) begin
      acc_d = acc_q + {{LOG2_DIV{diff_q[WIDTH]}}, diff_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
      diff_q  <= '0;
      acc_q   <= '0;
    end else begin
      first_q <= first_d;
      diff_q  <= diff_d;
      acc_q   <= acc_d;
    end
  end

  // Dropping the low LOG2_DIV bits of a two's-complement value is an
  // arithmetic right shift, i.e. floor division; the true sum always fits WIDTH.
  assign sum            = {1'b0, first_q} + acc_q[AW-1:LOG2_DIV];
  assign x_o            = sum[WIDTH-1:0];
  assign unused_sum_msb = sum[WIDTH];

endmodule

// File: rtl/grid_interp.sv
// Grid interpolator top: IDLE/RUN sweep control with valid/ready output.
// Define GRID_INTERP_ENDPOINT_EN to also emit the endpoint beat (k = N).
module grid_interp
  import grid_interp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOG2_DIV = DEF_LOG2_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    first_x,
  input  logic [WIDTH-1:0]    sec_x,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_x,
  output logic [LOG2_DIV:0]   out_idx,
  output logic                out_last,
  output logic                done
);

  localparam int N = 1 << LOG2_DIV;
`ifdef GRID_INTERP_ENDPOINT_EN
  localparam int K_LAST_I = N;
`else
  localparam int K_LAST_I = N - 1;
`endif
  localparam logic [LOG2_DIV:0] K_LAST = K_LAST_I[LOG2_DIV:0];

  state_e              state_q, state_d;
  logic [LOG2_DIV:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic                load;
  logic                hs;
  logic                is_last;

  assign load    = (state_q == IDLE) && start;
  assign hs      = out_valid && out_ready;
  assign is_last = (idx_q == K_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (hs) begin
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = busy;
  assign out_idx   = idx_q;
  assign out_last  = busy && is_last;
  assign done      = done_q;

  grid_interp_acc #(
    .WIDTH    (WIDTH),
    .LOG2_DIV (LOG2_DIV)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_i    (hs),
    .first_x_i (first_x),
    .sec_x_i   (sec_x),
    .x_o       (out_x)
  );

endmodule

// File: tb/tb_grid_interp.sv
// Scoreboard bench for grid_interp: expected beats queued at start, popped on handshake.
module tb_grid_interp;

  localparam int WIDTH    = 10;
  localparam int LOG2_DIV = 5;
  localparam int N        = 1 << LOG2_DIV;
`ifdef GRID_INTERP_ENDPOINT_EN
  localparam int K_LAST = N;
`else
  localparam int K_LAST = N - 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    first_x;
  logic [WIDTH-1:0]    sec_x;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_x;
  logic [LOG2_DIV:0]   out_idx;
  logic                out_last;
  logic                done;

  typedef struct {
    int x;
    int idx;
    int last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  grid_interp #(.WIDTH(WIDTH), .LOG2_DIV(LOG2_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_x   (first_x),
    .sec_x     (sec_x),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: first + floor(k*(sec-first)/N) with explicit floor for negatives.
  function automatic int model_x(input int fx, input int sx, input int k);
    int p;
    int q;
    p = k * (sx - fx);
    if (p >= 0) q = p / N;
    else        q = -((-p + N - 1) / N);
    return fx + q;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_last"},  int'(out_last), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_x"},     int'(out_x), 0);
    check({tag, "_idx"},   int'(out_idx), 0);
  endtask

  // hold_at: stall 3 cycles at that idx; rst_at: reset at that idx; poke: start pulses while busy.
  task automatic run_sweep(input int fx, input int sx, input int hold_at,
                           input int rst_at, input bit poke);
    beat_t e;
    for (int k = 0; k <= K_LAST; k++)
      exp_q.push_back('{x: model_x(fx, sx, k), idx: k, last: (k == K_LAST) ? 1 : 0});
    @(negedge clk);
    start = 1'b1; first_x = WIDTH'(fx); sec_x = WIDTH'(sx); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.idx == rst_at) begin
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk);
        check_zero("inreset");
        rst_n = 1'b1;
        exp_q.delete();
        $display("sweep %0d->%0d reset at idx %0d", fx, sx, e.idx);
        return;
      end
      if (e.idx == hold_at) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          check("hold_x",     int'(out_x), e.x);
          check("hold_idx",   int'(out_idx), e.idx);
          check("hold_valid", int'(out_valid), 1);
          @(negedge clk);
        end
      end
      if (poke && (e.idx == 3 || e.idx == K_LAST)) begin
        start = 1'b1; first_x = WIDTH'(7); sec_x = WIDTH'(900);
      end
      out_ready = 1'b1;
      check("valid", int'(out_valid), 1);
      check("x",     int'(out_x), e.x);
      check("idx",   int'(out_idx), e.idx);
      check("last",  int'(out_last), e.last);
      $display("beat idx=%0d x=%0d last=%0d exp_x=%0d", out_idx, out_x, out_last, e.x);
      @(negedge clk);
      start = 1'b0;
    end
    out_ready = 1'b0;
    check("done_pulse", int'(done), 1);
    check("busy_end",   int'(busy), 0);
    check("valid_end",  int'(out_valid), 0);
    @(negedge clk);
    check("done_clear", int'(done), 0);
    check("still_idle", int'(busy), 0);
    $display("sweep %0d->%0d complete", fx, sx);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_x = '0; sec_x = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    run_sweep(100, 420, -1, -1, 1'b0);
    run_sweep(420, 100, -1, -1, 1'b0);
    run_sweep(0, 33, -1, -1, 1'b0);
    run_sweep(33, 0, -1, -1, 1'b0);
    run_sweep(100, 420, 5, -1, 1'b0);
    run_sweep(100, 420, -1, 10, 1'b0);
    run_sweep(100, 420, -1, -1, 1'b1);
    run_sweep(1023, 0, -1, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_interp.md
GRID_INTERP -- requirements
Module: grid_interp

Interface
REQ-001 Parameter WIDTH, default 10: bit width of the marker positions and the output positions.
REQ-002 Parameter LOG2_DIV, default 5: the span is divided into N = 2^LOG2_DIV intervals; legal range is 1..8.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: request a new sweep; sampled only while busy=0.
REQ-006 Port first_x, input, WIDTH: first marker position (unsigned); captured on an accepted start.
REQ-007 Port sec_x, input, WIDTH: second marker position (unsigned); captured on an accepted start.
REQ-008 Port busy, output, 1: a sweep is in progress.
REQ-009 Port out_valid, output, 1: out_x, out_idx and out_last are valid.
REQ-010 Port out_ready, input, 1: the consumer accepts a beat.
REQ-011 Port out_x, output, WIDTH: interpolated grid position.
REQ-012 Port out_idx, output, LOG2_DIV+1: grid index k.
REQ-013 Port out_last, output, 1: the current beat is the final beat of the sweep.
REQ-014 Port done, output, 1: one-cycle pulse in the cycle after the final handshake.

Function
REQ-015 The block SHALL have two states, IDLE and RUN; busy=1 exactly in RUN.
REQ-016 In IDLE, start=1 at edge t SHALL latch first_x/sec_x, enter RUN, and present k=0 with out_valid=1 from cycle t+1.
REQ-017 A start asserted in RUN, including the cycle of the final handshake, SHALL be ignored.
REQ-018 diff = sec_x - first_x SHALL be computed signed at WIDTH+1 bits, so reversed markers (sec_x < first_x) produce decreasing positions.
REQ-019 out_x SHALL equal first_x + ((k*diff) >>> LOG2_DIV), using an arithmetic shift (floor division) on a signed accumulator of WIDTH+LOG2_DIV+1 bits.
REQ-020 The accumulator SHALL be updated incrementally: it adds diff on each handshake, with no multiplier.
REQ-021 A handshake is out_valid & out_ready; it SHALL advance k in the next cycle.
REQ-022 While out_valid=1 and out_ready=0, out_x, out_idx and out_last SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly when k = K_LAST.
REQ-024 After the handshake at K_LAST, the block SHALL return to IDLE next cycle with out_valid=0 and done=1 for one cycle.
REQ-025 out_x SHALL always lie between first_x and sec_x inclusive, with no WIDTH overflow.

Reset
REQ-026 Asserting rst_n=0 at any time, including mid-sweep, SHALL immediately force IDLE with busy, out_valid, out_last, done, out_x and out_idx all 0, and the latched markers cleared.
REQ-027 The first start after reset deassertion SHALL behave as in REQ-016.

Configuration
REQ-028 Macro GRID_INTERP_ENDPOINT_EN defined: K_LAST = N, so the sweep emits N+1 beats and the final beat equals sec_x.
REQ-029 Macro GRID_INTERP_ENDPOINT_EN undefined: K_LAST = N-1, so the sweep emits N beats and first_x is emitted but sec_x is not.

Structure
REQ-030 Package grid_interp_pkg SHALL hold the IDLE/RUN state typedef and the default WIDTH/LOG2_DIV constants.
REQ-031 Sub-module grid_interp_acc SHALL own the signed accumulator, the diff register and the shift/add output datapath; grid_interp owns the FSM and the handshake.

Verification
REQ-032 first_x=100, sec_x=420, ready=1 -> out_x=100,110,...,410; idx 0..31; last on idx 31; done one cycle later.
REQ-033 first_x=420, sec_x=100 -> out_x=420,410,...,110.
REQ-034 first_x=0, sec_x=33 -> idx1=1, idx31=31; first_x=33, sec_x=0 -> idx1=31 (floor of -33/32 = -2).
REQ-035 Hold ready=0 for 3 cycles at idx 5 (first_x=100, sec_x=420) -> out_x=150 and out_idx=5 stable, then the sweep resumes at idx 6.
REQ-036 Pull rst_n low at idx 10 -> all outputs 0 immediately; a new start then restarts at idx 0; a start pulsed mid-sweep has no effect.
REQ-037 With GRID_INTERP_ENDPOINT_EN, first_x=100, sec_x=420 -> 33 beats; idx 32 gives out_x=420 with out_last=1.
